// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data-memory port: responder FSM states,
// the out-of-range fill pattern and byte-lane geometry.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    RESP_IDLE,
    RESP_WAIT,
    RESP_DONE
  } resp_state_t;

  localparam int DATA_W = 32;
  localparam int LANE_W = 8;
  localparam int LANES  = DATA_W / LANE_W;

  localparam logic [DATA_W-1:0] MEM_BAD_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bram_be.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered read port.
// The read register only loads on read accesses, so it holds the last loaded word across writes.
module mem_bram_be
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [LANES-1:0]  we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (we[i]) begin
          mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
      if (we == '0) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_data_responder.sv
// Responder for the CPU data-memory port: on-chip RAM with byte-lane writes and programmable
// wait states. Define DATA_RESP_MMIO_EN to add the mmio_out output register at MMIO_ADDR.
module mem_data_responder
  import cpu_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MMIO_ADDR   = 32'hBFAF_F000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  output logic        data_err
`ifdef DATA_RESP_MMIO_EN
  ,
  output logic [31:0] mmio_out
`endif
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef DATA_RESP_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  // Wait counter decrements but parks at zero instead of wrapping.
  function automatic logic [3:0] sat_dec(input logic [3:0] c);
    sat_dec = (c == 4'd0) ? 4'd0 : c - 4'd1;
  endfunction

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [LANES-1:0]  we);
    lane_merge = old_w;
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) lane_merge[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
    end
  endfunction

  resp_state_t state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        go_resp;

  logic [31:0]       req_addr_p0;
  logic [LANES-1:0]  req_wen_p0;
  logic [DATA_W-1:0] req_wdata_p0;

  logic [31:0]       acc_addr;
  logic [LANES-1:0]  acc_wen;
  logic [DATA_W-1:0] acc_wdata;
  logic              hi_nz, mmio_hit, out_of_range, ram_sel, ram_en;

  logic              err_p1;
  logic              rd_ram_p1;
  logic [DATA_W-1:0] alt_rdata_p1;
  logic [DATA_W-1:0] mmio_q;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr_lsb;

  // Request capture: the CPU is only guaranteed to present it in the sampling IDLE cycle
  always_ff @(posedge clk) begin
    if (state == RESP_IDLE && data_en) begin
      req_addr_p0  <= data_addr;
      req_wen_p0   <= data_wen;
      req_wdata_p0 <= data_wdata;
    end
  end

  // With zero wait states the access fires straight from IDLE, before the latch holds it.
  assign acc_addr  = (state == RESP_IDLE) ? data_addr  : req_addr_p0;
  assign acc_wen   = (state == RESP_IDLE) ? data_wen   : req_wen_p0;
  assign acc_wdata = (state == RESP_IDLE) ? data_wdata : req_wdata_p0;

  assign hi_nz           = |acc_addr[31:ADDR_W+2];
  assign mmio_hit        = MMIO_EN && (acc_addr[31:2] == MMIO_ADDR[31:2]);
  assign out_of_range    = hi_nz && !mmio_hit;
  assign ram_sel         = !hi_nz && !mmio_hit;
  assign ram_en          = go_resp && ram_sel && !rst;
  assign unused_addr_lsb = ^acc_addr[1:0];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    go_resp  = 1'b0;
    unique case (state)
      RESP_IDLE: begin
        if (data_en) begin
          if (WAIT_STATES == 0) begin
            state_nx = RESP_DONE;
            go_resp  = 1'b1;
          end else begin
            state_nx = RESP_WAIT;
            cnt_nx   = WAIT_LOAD;
          end
        end
      end
      RESP_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP_DONE;
          go_resp  = 1'b1;
        end else begin
          cnt_nx = sat_dec(cnt);
        end
      end
      RESP_DONE: state_nx = RESP_IDLE;
      default:   state_nx = RESP_IDLE;
    endcase
  end

  // Response stage: everything below becomes visible in the RESP cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RESP_IDLE;
      cnt          <= 4'd0;
      err_p1       <= 1'b0;
      rd_ram_p1    <= 1'b0;
      alt_rdata_p1 <= '0;
      mmio_q       <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      err_p1 <= go_resp && out_of_range;
      if (go_resp && acc_wen == '0) begin
        rd_ram_p1    <= ram_sel;
        alt_rdata_p1 <= mmio_hit ? mmio_q : MEM_BAD_DATA;
      end
      if (go_resp && mmio_hit) begin
        mmio_q <= lane_merge(mmio_q, acc_wdata, acc_wen);
      end
    end
  end

  mem_bram_be #(
    .DEPTH (DEPTH_WORDS),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (acc_wen),
    .addr (acc_addr[ADDR_W+1:2]),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

  assign data_rdata = rd_ram_p1 ? ram_rdata : alt_rdata_p1;
  assign data_err   = err_p1;
  assign data_stall = !rst && (((state == RESP_IDLE) && data_en) || (state == RESP_WAIT));

`ifdef DATA_RESP_MMIO_EN
  assign mmio_out = mmio_q;
`endif

endmodule
